// File: rtl/uart_rx_if.sv
// Serial line, per-frame configuration and received-character outputs of uart_rx.
// The slave modport is the receiver's view; the master modport is the driver/consumer side.
interface uart_rx_if;
    logic       rx;
    logic       data_size;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       stop_bit_size;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx, data_size, parity_en, parity_mode, stop_bit_size,
        output data, valid, parity_err, frame_err, busy
    );

    modport master (
        output rx, data_size, parity_en, parity_mode, stop_bit_size,
        input  data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional parity and 1/2 stop bits.
// Each bit is sampled at its 8th sample tick; results are published with a one-cycle valid pulse.
module uart_rx #(
    parameter int SAMPLE_DIV = 81
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    logic             r_stop_cnt;
    logic             r_cfg_size;
    logic             r_cfg_pen;
    logic [1:0]       r_cfg_pmode;
    logic             r_cfg_stop;
    logic [7:0]       r_shift;
    logic             r_par_bit;
    logic             r_ferr_acc;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_busy;

    logic             w_tick;
    logic             w_mid;
    logic             w_fall;
    logic             w_last_bit;
    logic             w_last_stop;
    logic             w_perr;
    logic             w_confirm;
    logic             w_done;

    function automatic logic f_parity_expected(input logic [7:0] d, input logic [1:0] mode);
        case (mode)
            2'b11:   return ~^d;
            2'b10:   return ^d;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign w_tick      = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign w_mid       = w_tick && (r_tick_cnt == 4'd7);
    assign w_fall      = r_rx_prev && !r_rx_sync;
    assign w_last_bit  = (r_bit_cnt == (r_cfg_size ? 3'd7 : 3'd6));
    assign w_last_stop = (r_stop_cnt == r_cfg_stop);
    // In 7-bit mode r_shift[7] stays 0, so it never disturbs the reduction.
    assign w_perr      = r_cfg_pen && (r_par_bit != f_parity_expected(r_shift, r_cfg_pmode));

    always_comb begin
        w_state_nxt = r_state;
        w_confirm   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_mid) begin
                    w_state_nxt = r_rx_sync ? IDLE : DATA;
                    w_confirm   = !r_rx_sync;
                end
            end
            DATA: begin
                if (w_mid && w_last_bit) w_state_nxt = r_cfg_pen ? PARITY : STOP;
            end
            PARITY: begin
                if (w_mid) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_mid && w_last_stop) begin
                    w_done      = 1'b1;
                    w_state_nxt = r_rx_sync ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (r_rx_sync) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_cfg_size  <= 1'b0;
            r_cfg_pen   <= 1'b0;
            r_cfg_pmode <= 2'b00;
            r_cfg_stop  <= 1'b0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_ferr_acc  <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_state_nxt;
            r_valid   <= 1'b0;

            // Sample timing is held at zero while idle so it restarts exactly at the start edge.
            if (r_state == IDLE || r_state == WAIT_IDLE) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
                r_div_cnt  <= r_div_cnt + 1'b1;
            end

            if (r_state == IDLE && w_fall) begin
                r_cfg_size  <= bus.data_size;
                r_cfg_pen   <= bus.parity_en;
                r_cfg_pmode <= bus.parity_mode;
                r_cfg_stop  <= bus.stop_bit_size;
                r_shift     <= '0;
                r_bit_cnt   <= '0;
                r_stop_cnt  <= 1'b0;
                r_par_bit   <= 1'b0;
                r_ferr_acc  <= 1'b0;
            end

            if (w_confirm) r_busy <= 1'b1;

            if (r_state == DATA && w_mid) begin
                r_shift[r_bit_cnt] <= r_rx_sync;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end

            if (r_state == PARITY && w_mid) r_par_bit <= r_rx_sync;

            if (r_state == STOP && w_mid) begin
                r_stop_cnt <= 1'b1;
                if (!r_rx_sync) r_ferr_acc <= 1'b1;
            end

            if (w_done) begin
                r_data  <= r_shift;
                r_perr  <= w_perr;
                r_ferr  <= r_ferr_acc | ~r_rx_sync;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed and loopback-style bench for uart_rx: frames are serialised by the bench at the
// receiver's bit rate and the published character/flags are compared with expected values.
module tb_uart_rx;
    localparam int SDIV = 3;
    localparam int BIT  = 16 * SDIV;

    logic clk;
    logic rst;
    uart_rx_if bus ();

    uart_rx #(.SAMPLE_DIV(SDIV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    int         n_busy   = 0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            n_valid  = n_valid + 1;
            cap_data = bus.data;
            cap_perr = bus.parity_err;
            cap_ferr = bus.frame_err;
        end
        if (bus.busy === 1'b1) n_busy = n_busy + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'b11:   return ~^d;
            2'b10:   return ^d;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic eight, input logic pen,
                              input logic pbit, input logic two_stop, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < (eight ? 8 : 7); i++) drive_bit(b[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop_val);
        if (two_stop) drive_bit(stop_val);
    endtask

    task automatic set_cfg(input logic ds, input logic pen, input logic [1:0] pm, input logic sb);
        bus.data_size     = ds;
        bus.parity_en     = pen;
        bus.parity_mode   = pm;
        bus.stop_bit_size = sb;
    endtask

    initial begin
        int         v0;
        int         b0;
        logic [7:0] b;
        logic [7:0] bexp;
        logic       eight;
        logic       pen;
        logic       two;
        logic [1:0] pm;

        bus.rx = 1'b1;
        set_cfg(1'b0, 1'b0, 2'b00, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data",  bus.data,       8'h00);
        check("rst_valid", bus.valid,      1'b0);
        check("rst_perr",  bus.parity_err, 1'b0);
        check("rst_ferr",  bus.frame_err,  1'b0);
        check("rst_busy",  bus.busy,       1'b0);
        drive_bit(1'b1);

        // 8-bit odd parity, 1 stop, 0xAA; config is changed mid-frame and must be ignored.
        set_cfg(1'b1, 1'b1, 2'b11, 1'b0);
        v0 = n_valid;
        fork
            send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            begin
                repeat (3 * BIT) @(negedge clk);
                set_cfg(1'b0, 1'b0, 2'b00, 1'b1);
            end
        join
        drive_bit(1'b1);
        check("aa_valid", n_valid - v0, 1);
        check("aa_data",  cap_data,     8'hAA);
        check("aa_perr",  cap_perr,     1'b0);
        check("aa_ferr",  cap_ferr,     1'b0);
        drive_bit(1'b1);
        check("aa_hold",  bus.data,     8'hAA);

        // 7-bit even parity, 2 stop, 0x55: correct parity bit 0, then wrong parity bit 1.
        set_cfg(1'b0, 1'b1, 2'b10, 1'b1);
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);
        check("p55_valid", n_valid - v0, 1);
        check("p55_data",  cap_data,     8'h55);
        check("p55_perr",  cap_perr,     1'b0);
        check("p55_ferr",  cap_ferr,     1'b0);
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1);
        check("bad55_valid", n_valid - v0, 1);
        check("bad55_data",  cap_data,     8'h55);
        check("bad55_perr",  cap_perr,     1'b1);
        check("bad55_ferr",  cap_ferr,     1'b0);

        // Start glitch of 4 sample ticks.
        v0 = n_valid;
        b0 = n_busy;
        bus.rx = 1'b0;
        repeat (4 * SDIV) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_busy",  n_busy - b0,  0);

        // 8-bit no parity, 0x3C with low stop bit, then break held low for 3 bit times.
        set_cfg(1'b1, 1'b0, 2'b00, 1'b0);
        v0 = n_valid;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("brk_valid", n_valid - v0, 1);
        check("brk_data",  cap_data,     8'h3C);
        check("brk_ferr",  cap_ferr,     1'b1);
        check("brk_busy",  bus.busy,     1'b0);
        drive_bit(1'b1);
        v0 = n_valid;
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check("post_brk_valid", n_valid - v0, 1);
        check("post_brk_data",  cap_data,     8'h12);
        check("post_brk_ferr",  cap_ferr,     1'b0);

        // Reset during data bit 4 of 0xF0, then a clean 0x81 frame.
        v0 = n_valid;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        check("mid_busy", bus.busy, 1'b1);
        bus.rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_data",  bus.data,       8'h00);
        check("mrst_valid", bus.valid,      1'b0);
        check("mrst_perr",  bus.parity_err, 1'b0);
        check("mrst_ferr",  bus.frame_err,  1'b0);
        check("mrst_busy",  bus.busy,       1'b0);
        repeat (5 * BIT) @(negedge clk);
        check("mrst_novalid", n_valid - v0, 0);
        v0 = n_valid;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check("r81_valid", n_valid - v0, 1);
        check("r81_data",  cap_data,     8'h81);
        check("r81_ferr",  cap_ferr,     1'b0);

        // Every combination of size, parity enable, stop bits and parity mode with random bytes.
        for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 2; k++) begin
                b     = 8'($urandom_range(0, 255));
                eight = c[0];
                pen   = c[1];
                two   = c[2];
                pm    = 2'(c >> 3);
                bexp  = eight ? b : {1'b0, b[6:0]};
                set_cfg(eight, pen, pm, two);
                v0 = n_valid;
                send_frame(b, eight, pen, exp_parity(bexp, pm), two, 1'b1);
                drive_bit(1'b1);
                check($sformatf("lb%0d_%0d_valid", c, k), n_valid - v0, 1);
                check($sformatf("lb%0d_%0d_data", c, k),  cap_data,     bexp);
                check($sformatf("lb%0d_%0d_perr", c, k),  cap_perr,     1'b0);
                check($sformatf("lb%0d_%0d_ferr", c, k),  cap_ferr,     1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
